bmem_burst_responder: RTL and testbench

// - Memory-side end of the 64-bit burst bus. Responds to line requests from the cache-side deserializer.
// - Reads: accepts a read, waits a fixed latency, then streams a 256-bit line as 4 x 64-bit beats.
// - Writes: collects 4 x 64-bit write beats into one line, then commits the line to an internal line store.
// - Used as the backing-memory model for core and cache benches, and as a bring-up stand-in for the real controller.

---
 rtl/bmem_pkg.sv | 27 ++
 rtl/bmem_burst_responder_if.sv | 26 ++
 rtl/bmem_read_queue.sv | 71 +++++++
 rtl/bmem_burst_responder.sv | 158 +++++++++++++++
 tb/tb_bmem_burst_responder.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bmem_pkg.sv
// Shared types and constants for the 64-bit burst bus and its 256-bit line store.
// A line travels as four 64-bit beats; beat k carries line bits [64k+63:64k].
package bmem_pkg;

  localparam int BEAT_W           = 64;
  localparam int LINE_W           = 256;
  localparam int BEATS_PER_LINE   = 4;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int ADDR_W           = 32;
  localparam int AGE_W            = 8;

  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [AGE_W-1:0]  age_t;

  typedef struct packed {
    addr_t addr;
    age_t  age;
  } rd_req_t;

  // Byte address rounded down to the start of its line.
  function automatic addr_t line_base(input addr_t a);
    return {a[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/bmem_burst_responder_if.sv
// Burst bus between the cache-side deserializer (master) and the memory-side
// responder (slave).
interface bmem_burst_responder_if;
  import bmem_pkg::*;

  addr_t bmem_addr;
  logic  bmem_read;
  logic  bmem_write;
  beat_t bmem_wdata;
  logic  bmem_ready;
  addr_t bmem_raddr;
  beat_t bmem_rdata;
  logic  bmem_rvalid;
  logic  proto_err;

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, proto_err
  );

  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, proto_err
  );

endinterface

// File: rtl/bmem_read_queue.sv
// FIFO of accepted reads. Each entry carries an age that counts cycles since
// acceptance (the accept cycle included), saturating at LATENCY.
module bmem_read_queue
  import bmem_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  addr_t push_addr,
  input  logic  pop,
  output addr_t head_addr,
  output logic  head_ripe,
  output logic  full,
  output logic  empty
);

  localparam int   PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int   CNT_W   = $clog2(DEPTH + 1);
  localparam age_t AGE_MAX = age_t'(LATENCY);

  rd_req_t          entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A simultaneous pop frees the slot the push needs, even when full.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // NOTE: the entry array is small and reset with the pointers so a
      // freshly reset queue never exposes stale addresses or ages.
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].age < AGE_MAX) entries[i].age <= entries[i].age + 1'b1;
      end
      if (do_push) begin
        entries[wr_ptr] <= '{addr: push_addr, age: age_t'(1)};
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_addr = entries[rd_ptr].addr;
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign head_ripe = !empty && (entries[rd_ptr].age >= AGE_MAX);

endmodule

// File: rtl/bmem_burst_responder.sv
// Memory-side end of the 64-bit burst bus: queues line reads and streams them
// back as 4 beats after a fixed latency, and assembles 4 write beats into a line.
module bmem_burst_responder
  import bmem_pkg::*;
#(
  parameter int LINES        = 64,
  parameter int READ_LATENCY = 4,
  parameter int QUEUE_DEPTH  = 4
) (
  input logic                    clk,
  input logic                    rst,
  bmem_burst_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(LINES);
  typedef logic [IDX_W-1:0] idx_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BEAT0 = 3'd1;
  localparam logic [2:0] S_BEAT1 = 3'd2;
  localparam logic [2:0] S_BEAT2 = 3'd3;
  localparam logic [2:0] S_BEAT3 = 3'd4;

  function automatic idx_t line_idx(input addr_t a);
    return a[LINE_OFFSET_BITS +: IDX_W];
  endfunction

  line_t      store [LINES];

  logic [2:0] state;
  logic [2:0] state_next;
  line_t      shift_q;
  addr_t      raddr_q;
  logic       err_q;

  logic [1:0] wr_cnt;
  addr_t      wr_addr;
  beat_t      wr_beat0;
  beat_t      wr_beat1;
  beat_t      wr_beat2;

  addr_t      head_addr;
  logic       head_ripe;
  logic       q_full;
  logic       q_empty;

  logic       wr_accept;
  logic       rd_accept;
  logic       rd_push;
  logic       rd_conflict;
  logic       rd_mid_burst;
  logic       addr_change;
  logic       wr_commit;
  logic       load;

  assign bus.bmem_ready = !q_full;

  // A read is only queued when it is alone on the bus and no write burst is open.
  assign wr_accept    = bus.bmem_write && bus.bmem_ready;
  assign rd_accept    = bus.bmem_read && bus.bmem_ready;
  assign rd_push      = rd_accept && !bus.bmem_write && (wr_cnt == 2'd0);
  assign rd_conflict  = bus.bmem_read && bus.bmem_write;
  assign rd_mid_burst = rd_accept && !bus.bmem_write && (wr_cnt != 2'd0);
  assign addr_change  = wr_accept && (wr_cnt != 2'd0) &&
                        (line_base(bus.bmem_addr) != wr_addr);
  assign wr_commit    = wr_accept && (wr_cnt == 2'd3);

  // A ripe head starts a stream from idle, or chains straight after the last beat.
  assign load = !q_empty && head_ripe && ((state == S_IDLE) || (state == S_BEAT3));

  bmem_read_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .LATENCY (READ_LATENCY)
  ) u_read_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_push),
    .push_addr (line_base(bus.bmem_addr)),
    .pop       (load),
    .head_addr (head_addr),
    .head_ripe (head_ripe),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    case (state)
      S_IDLE:  if (load) state_next = S_BEAT0;
      S_BEAT0: state_next = S_BEAT1;
      S_BEAT1: state_next = S_BEAT2;
      S_BEAT2: state_next = S_BEAT3;
      S_BEAT3: state_next = load ? S_BEAT0 : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Stream engine: capture the whole line on entry to BEAT0, then shift a beat out per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      shift_q <= '0;
      raddr_q <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        shift_q <= store[line_idx(head_addr)];
        raddr_q <= head_addr;
      end else if (state != S_IDLE) begin
        shift_q <= shift_q >> BEAT_W;
      end
    end
  end

  // Write assembler: beats 0..2 are buffered, beat 3 completes the line in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt   <= '0;
      wr_addr  <= '0;
      wr_beat0 <= '0;
      wr_beat1 <= '0;
      wr_beat2 <= '0;
    end else if (wr_accept) begin
      case (wr_cnt)
        2'd0: begin
          wr_beat0 <= bus.bmem_wdata;
          wr_addr  <= line_base(bus.bmem_addr);
        end
        2'd1:    wr_beat1 <= bus.bmem_wdata;
        2'd2:    wr_beat2 <= bus.bmem_wdata;
        default: ;
      endcase
      wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // A capture of the line being committed on the same edge sees the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) store[i] <= '0;
    end else if (wr_commit) begin
      store[line_idx(wr_addr)] <= {bus.bmem_wdata, wr_beat2, wr_beat1, wr_beat0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | rd_conflict | rd_mid_burst | addr_change;
  end

  assign bus.bmem_rvalid = (state != S_IDLE);
  assign bus.bmem_rdata  = shift_q[BEAT_W-1:0];
  assign bus.bmem_raddr  = raddr_q;
  assign bus.proto_err   = err_q;

endmodule

// File: tb/tb_bmem_burst_responder.sv
// Directed bench for bmem_burst_responder: a line-store model feeds a scoreboard
// of expected read beats that a negedge monitor drains as the DUT streams.
module tb_bmem_burst_responder;
  import bmem_pkg::*;

  localparam int LINES = 64;
  localparam int LAT   = 4;
  localparam int QD    = 4;

  logic clk = 1'b0;
  logic rst;

  bmem_burst_responder_if bus();

  bmem_burst_responder #(
    .LINES        (LINES),
    .READ_LATENCY (LAT),
    .QUEUE_DEPTH  (QD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    addr_t addr;
    beat_t data;
  } exp_beat_t;

  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        beat_cnt = 0;
  int        first_beat = -1;
  int        last_beat = -1;
  exp_beat_t sb[$];
  line_t     model [LINES];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int midx(input addr_t a);
    return int'((a >> LINE_OFFSET_BITS) % LINES);
  endfunction

  function automatic line_t pat(input addr_t a, input int s);
    line_t l;
    for (int k = 0; k < BEATS_PER_LINE; k++) l[64*k +: 64] = {a, 8'(s), 20'h0, 4'(k)};
    return l;
  endfunction

  // Every rvalid beat must match the oldest expected beat.
  always @(negedge clk) begin
    exp_beat_t e;
    if (!rst && bus.bmem_rvalid) begin
      beat_cnt++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'(bus.bmem_rvalid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("raddr", 64'(bus.bmem_raddr), 64'(e.addr));
        check("rdata", bus.bmem_rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < LINES; i++) model[i] = '0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
    bus.bmem_addr  = '0;
    bus.bmem_wdata = '0;
    repeat (2) tick();
    clear_model();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.bmem_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_wait", 64'(bus.bmem_ready), 64'd1);
  endtask

  task automatic issue_read(input addr_t a);
    line_t l;
    wait_ready();
    bus.bmem_addr = a;
    bus.bmem_read = 1'b1;
    tick();
    bus.bmem_read = 1'b0;
    l = model[midx(a)];
    for (int k = 0; k < BEATS_PER_LINE; k++)
      sb.push_back('{addr: line_base(a), data: l[64*k +: 64]});
  endtask

  // mode: 0 plain, 1 idle gap before beat 2, 2 read with beat 0,
  // 3 lone read before beat 2, 4 other address on beat 2.
  task automatic write_line(input addr_t a, input line_t l, input int mode);
    for (int k = 0; k < BEATS_PER_LINE; k++) begin
      if (mode == 1 && k == 2) tick();
      if (mode == 3 && k == 2) begin
        bus.bmem_addr = a;
        bus.bmem_read = 1'b1;
        tick();
        bus.bmem_read = 1'b0;
      end
      bus.bmem_addr  = (mode == 4 && k == 2) ? a + 32'h20 : a;
      bus.bmem_wdata = l[64*k +: 64];
      bus.bmem_write = 1'b1;
      bus.bmem_read  = (mode == 2 && k == 0);
      tick();
      bus.bmem_write = 1'b0;
      bus.bmem_read  = 1'b0;
    end
    model[midx(a)] = l;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.bmem_rvalid) && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(sb.size()), 64'd0);
    repeat (8) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    line_t l1;
    int    n;

    do_reset();
    check("rst_ready",  64'(bus.bmem_ready),  64'd1);
    check("rst_rvalid", 64'(bus.bmem_rvalid), 64'd0);
    check("rst_rdata",  bus.bmem_rdata,       64'd0);
    check("rst_raddr",  64'(bus.bmem_raddr),  64'd0);
    check("rst_err",    64'(bus.proto_err),   64'd0);

    // 1: write then read 0x40; first beat READ_LATENCY cycles after accept.
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    write_line(32'h40, l1, 0);
    issue_read(32'h40);
    for (int i = 1; i <= LAT; i++) begin
      tick();
      check("t1_latency", 64'(bus.bmem_rvalid), 64'(i == LAT));
    end
    drain("t1_drain");

    // 2: five back-to-back reads; queue fills after the fourth.
    write_line(32'h00, pat(32'h00, 2), 0);
    write_line(32'h20, pat(32'h20, 2), 0);
    write_line(32'h60, pat(32'h60, 2), 0);
    write_line(32'h80, pat(32'h80, 2), 0);
    beat_cnt   = 0;
    first_beat = -1;
    for (int i = 0; i < 5; i++) begin
      issue_read(addr_t'(32 * i));
      if (i == 3) check("t2_ready_low", 64'(bus.bmem_ready), 64'd0);
    end
    drain("t2_drain");
    check("t2_beats", 64'(beat_cnt), 64'd20);
    check("t2_no_gaps", 64'(last_beat - first_beat + 1), 64'd20);

    // 3: write with an idle cycle between beats 1 and 2.
    write_line(32'h100, pat(32'h100, 3), 1);
    issue_read(32'h100);
    drain("t3_drain");
    check("t3_err", 64'(bus.proto_err), 64'd0);

    // 4: commit and capture of 0x20 on the same edge, then a read right after.
    issue_read(32'h20);
    write_line(32'h20, pat(32'h20, 4), 0);
    issue_read(32'h20);
    issue_read(32'hFFFF_F820);
    drain("t4_drain");
    check("t4_err", 64'(bus.proto_err), 64'd0);

    // 5a: read together with a write beat.
    do_reset();
    write_line(32'h180, pat(32'h180, 5), 2);
    check("t5a_err", 64'(bus.proto_err), 64'd1);
    issue_read(32'h180);
    drain("t5a_drain");

    // 5b: lone read inside a write burst.
    do_reset();
    write_line(32'h180, pat(32'h180, 6), 3);
    check("t5b_err", 64'(bus.proto_err), 64'd1);
    issue_read(32'h180);
    drain("t5b_drain");

    // 5c: address change inside a write burst keeps the beat-0 address.
    do_reset();
    write_line(32'h180, pat(32'h180, 7), 4);
    check("t5c_err", 64'(bus.proto_err), 64'd1);
    issue_read(32'h180);
    issue_read(32'h1A0);
    drain("t5c_drain");

    // 6: reset during BEAT1 with two reads still queued.
    do_reset();
    write_line(32'h40, pat(32'h40, 8), 0);
    issue_read(32'h40);
    issue_read(32'h60);
    issue_read(32'h80);
    n = 0;
    while (!bus.bmem_rvalid && n < 20) begin
      tick();
      n++;
    end
    check("t6_stream_start", 64'(bus.bmem_rvalid), 64'd1);
    tick();
    rst = 1'b1;
    #1;
    check("t6_rvalid_async", 64'(bus.bmem_rvalid), 64'd0);
    check("t6_rdata_async",  bus.bmem_rdata,       64'd0);
    clear_model();
    tick();
    tick();
    rst = 1'b0;
    repeat (12) tick();
    check("t6_ready", 64'(bus.bmem_ready), 64'd1);
    check("t6_err",   64'(bus.proto_err),  64'd0);
    issue_read(32'h40);
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
